// File: rtl/p20_collision_ctrl_if.sv
// p20_collision_ctrl_if: player, frame and obstacle inputs plus game-control outputs
// master drives button/frame_tick/jump_pos/obs_*; slave drives jump/halt/game_rst/score/state
interface p20_collision_ctrl_if;
  logic        button;
  logic        frame_tick;
  logic [6:0]  jump_pos;
  logic        obs_valid;
  logic [7:0]  obs_x;
  logic [6:0]  obs_h;
  logic        jump;
  logic        halt;
  logic        game_rst;
  logic [13:0] score;
  logic [1:0]  state;
  modport master (
    output button, frame_tick, jump_pos, obs_valid, obs_x, obs_h,
    input  jump, halt, game_rst, score, state
  );
  modport slave (
    input  button, frame_tick, jump_pos, obs_valid, obs_x, obs_h,
    output jump, halt, game_rst, score, state
  );
endinterface

// File: rtl/p20_collision_ctrl.sv
// p20_collision_ctrl: debounced button, dino/obstacle collision, IDLE/RUN/DEAD game FSM with score
// clk, sys_rst (async active-high); bus: button, frame_tick, jump_pos, obs_* in; jump, halt, game_rst, score, state out
module p20_collision_ctrl #(
  parameter int DINO_X    = 16,
  parameter int DINO_W    = 12,
  parameter int OBS_W     = 8,
  parameter int DB_CYCLES = 50000,
  parameter int HOLDOFF   = 32
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  p20_collision_ctrl_if.slave   bus
);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic [13:0] SCORE_MAX = 14'd9999;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DEAD = 2'b10} state_t;
  state_t        st;
  logic          s0, s1, btn_db, btn_q, press, hit, restart;
  logic          jump, halt, game_rst;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold;
  logic [13:0]   score;
  logic [8:0]    ox;
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      s0     <= 1'b0;
      s1     <= 1'b0;
      btn_db <= 1'b0;
      btn_q  <= 1'b0;
      db_cnt <= '0;
    end else begin
      s0     <= bus.button;
      s1     <= s0;
      btn_q  <= btn_db;
      db_cnt <= (s1 == btn_db || db_cnt == DW'(DB_CYCLES - 1)) ? '0 : db_cnt + DW'(1);
      if (s1 != btn_db && db_cnt == DW'(DB_CYCLES - 1)) btn_db <= s1;
    end
  end
  assign press = btn_db & ~btn_q;
  // 9-bit arithmetic so obs_x + OBS_W cannot wrap near the right screen edge
  assign ox  = {1'b0, bus.obs_x};
  assign hit = bus.obs_valid && ox < 9'(DINO_X + DINO_W) && ox + 9'(OBS_W) > 9'(DINO_X)
               && bus.jump_pos < bus.obs_h;
  assign restart = press && (st == IDLE || (st == DEAD && hold == HW'(HOLDOFF)));
  // collision is tested before the jump branch, so a coincident press loses to the hit
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      st       <= IDLE;
      halt     <= 1'b1;
      jump     <= 1'b0;
      game_rst <= 1'b0;
      score    <= '0;
      hold     <= '0;
    end else begin
      jump     <= 1'b0;
      game_rst <= restart;
      if (restart) begin
        st    <= RUN;
        halt  <= 1'b0;
        score <= '0;
      end else if (st == RUN && bus.frame_tick && hit) begin
        st   <= DEAD;
        halt <= 1'b1;
        hold <= '0;
      end else if (st == RUN) begin
        jump <= press;
        if (bus.frame_tick && score != SCORE_MAX) score <= score + 14'd1;
      end else if (st == DEAD && bus.frame_tick && hold != HW'(HOLDOFF)) begin
        hold <= hold + HW'(1);
      end
    end
  end
  assign bus.jump     = jump;
  assign bus.halt     = halt;
  assign bus.game_rst = game_rst;
  assign bus.score    = score;
  assign bus.state    = st;
endmodule

// File: doc/p20_collision_ctrl.md
P20_COLLISION_CTRL -- requirements
Module: p20_collision_ctrl

Interface
REQ-001 SHALL have parameter DINO_X, default 16: dino left edge in pixels.
REQ-002 SHALL have parameter DINO_W, default 12: dino width in pixels.
REQ-003 SHALL have parameter OBS_W, default 8: obstacle width in pixels.
REQ-004 SHALL have parameter DB_CYCLES, default 50000: clocks the button must be stable before it is accepted.
REQ-005 SHALL have parameter HOLDOFF, default 32: frame ticks in DEAD before a restart is accepted.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic runs on its rising edge.
REQ-007 SHALL have port sys_rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port button, input, 1: raw, asynchronous player button.
REQ-009 SHALL have port frame_tick, input, 1: one-clock pulse per video frame.
REQ-010 SHALL have port jump_pos, input, 7: dino height above ground, from the jump engine.
REQ-011 SHALL have port obs_valid, input, 1: an obstacle is on screen.
REQ-012 SHALL have port obs_x, input, 8: obstacle left edge in pixels.
REQ-013 SHALL have port obs_h, input, 7: obstacle height in pixels.
REQ-014 SHALL have port jump, output, 1: one-clock jump request to the jump engine.
REQ-015 SHALL have port halt, output, 1: freezes the jump engine and scrolling.
REQ-016 SHALL have port game_rst, output, 1: one-clock game restart pulse.
REQ-017 SHALL have port score, output, 14: frames survived, binary.
REQ-018 SHALL have port state, output, 2: FSM state, IDLE=00, RUN=01, DEAD=10.

Function
REQ-019 SHALL pass button through a 2-flop synchronizer, then a debouncer: the accepted level btn_db changes only after the synchronized value differs from btn_db for DB_CYCLES consecutive clocks.
REQ-020 SHALL generate press, an internal one-clock pulse, on each 0->1 transition of btn_db; the debouncer SHALL add at most DB_CYCLES+3 clocks of latency from the button edge to press.
REQ-021 SHALL define hit as: obs_valid && obs_x < DINO_X+DINO_W && obs_x+OBS_W > DINO_X && jump_pos < obs_h, computed at 9-bit width so the sums cannot wrap.
REQ-022 SHALL, in IDLE, hold halt=1; a press SHALL pulse game_rst for the next clock, clear score, and enter RUN on that same edge.
REQ-023 SHALL, in RUN, hold halt=0; each press SHALL pulse jump for exactly one clock, registered one cycle after the press.
REQ-024 SHALL, in RUN, sample hit only on frame_tick cycles; frame_tick with hit SHALL enter DEAD and set halt=1 on the next edge.
REQ-025 SHALL, in RUN, increment score on each frame_tick without hit, saturating at 9999.
REQ-026 SHALL, on entering DEAD, clear a hold-off counter; the counter SHALL increment on each frame_tick and saturate at HOLDOFF.
REQ-027 SHALL, in DEAD, ignore press until the hold-off counter equals HOLDOFF; after that, a press SHALL behave as REQ-022, so score holds its final value until the restart.
REQ-028 SHALL give collision priority when press and frame_tick with hit coincide in RUN: enter DEAD, no jump pulse.
REQ-029 SHALL never assert jump outside RUN, and SHALL never assert jump and game_rst in the same cycle.
REQ-030 SHALL ignore frame_tick for scoring in IDLE and DEAD.
REQ-031 SHALL register all outputs; state SHALL reflect the current FSM register.

Reset
REQ-032 SHALL, on sys_rst assertion at any time including mid-game or mid-debounce, asynchronously force: state=IDLE, halt=1, jump=0, game_rst=0, score=0, btn_db=0, debounce and hold-off counters=0, synchronizer flops=0.
REQ-033 SHALL resume normal operation on the first rising clk edge after sys_rst deasserts.

Verification
REQ-034 SHALL cover power-up: assert sys_rst, then release -> state=00, halt=1, score=0, no pulses; hold button high for DB_CYCLES+3 clocks -> exactly one game_rst pulse, state=01, halt=0.
REQ-035 SHALL cover a glitch and a jump: in RUN, button high for DB_CYCLES-1 clocks then low -> no jump; button high for DB_CYCLES+3 clocks -> exactly one 1-clock jump pulse.
REQ-036 SHALL cover collision and its boundary: obs_valid=1, obs_x=20, obs_h=10, jump_pos=9, frame_tick -> state=10, halt=1, score frozen; repeat with jump_pos=10 -> stays 01, score+1; repeat with obs_x=28 -> stays 01, and with obs_x=27 -> 10.
REQ-037 SHALL cover hold-off: in DEAD, press after 31 frame ticks -> ignored; press after 32 ticks -> game_rst pulse, score=0, state=01.
REQ-038 SHALL cover saturation and priority: force score=9998, 3 clean frame ticks -> score=9999; press coincident with a hitting frame_tick -> DEAD, jump stays 0.
REQ-039 SHALL cover reset mid-operation: assert sys_rst asynchronously between clock edges in RUN with score=57 -> all outputs at reset values immediately, before the next clk edge.
